// File: rtl/wb_mac_neuron_n.sv
// wb_mac_neuron_n: Wishbone-slave neuron accelerator.
// It holds CH signed weights, CH signed inputs and a bias, and runs a
// sequential saturating multiply-accumulate followed by an optional ReLU.
module wb_mac_neuron_n #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          irq_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          sat_o,
  output logic [CH-1:0] ch_active_o,
  output logic [7:0]    la_dbg_o
);

  localparam int unsigned IDX_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned PROD_W = 2 * DW;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_BIAS   = 8'h02;
  localparam logic [7:0] REG_RESULT = 8'h03;
  localparam logic [3:0] GRP_WEIGHT = 4'h1;
  localparam logic [3:0] GRP_INPUT  = 4'h2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [ACC_W-1:0]    bias_q, bias_d;
  logic                mode_q, mode_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic                busy_q, busy_d;
  logic                irq_q, irq_d;
  logic [CH-1:0]       ch_active_q, ch_active_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [DW-1:0]       weight_q [CH];
  logic [DW-1:0]       weight_d [CH];
  logic [DW-1:0]       input_q  [CH];
  logic [DW-1:0]       input_d  [CH];

  logic                req_c;
  logic                wr_c;
  logic                rd_c;
  logic                start_c;
  logic [7:0]          reg_idx_c;
  logic [3:0]          nib_c;
  logic                nib_ok_c;
  logic [31:0]         rdata_c;
  logic [DW-1:0]       w_sel_c;
  logic [DW-1:0]       x_sel_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W:0]    sum_c;
  logic                ovf_c;
  logic [ACC_W-1:0]    mac_c;
  logic                unused_c;

  // Bits of the bus that carry no information for this block.
  assign unused_c = ^{wbs_sel_i, wbs_adr_i[31:24], wbs_adr_i[15:0], wbs_dat_i};

  // Request decode: a new request is one not already being acknowledged.
  always_comb begin
    req_c     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    wr_c      = req_c & wbs_we_i;
    rd_c      = req_c & ~wbs_we_i;
    reg_idx_c = wbs_adr_i[23:16];
    nib_c     = reg_idx_c[3:0];
    nib_ok_c  = (32'(nib_c) < CH);
  end

  // Read data multiplexer; unmapped indices return zero.
  always_comb begin
    rdata_c = '0;
    case (reg_idx_c)
      REG_CTRL:   rdata_c = {29'd0, irq_en_q, mode_q, 1'b0};
      REG_STATUS: rdata_c = {29'd0, sat_q, done_q, busy_q};
      REG_BIAS:   rdata_c = 32'($signed(bias_q));
      REG_RESULT: rdata_c = 32'($signed(result_q));
      default: begin
        for (int unsigned i = 0; i < CH; i++) begin
          if (nib_ok_c && (nib_c == 4'(i))) begin
            if (reg_idx_c[7:4] == GRP_WEIGHT) rdata_c = 32'($signed(weight_q[i]));
            if (reg_idx_c[7:4] == GRP_INPUT)  rdata_c = 32'($signed(input_q[i]));
          end
        end
      end
    endcase
  end

  // Saturating MAC datapath for the channel selected by idx.
  always_comb begin
    w_sel_c = '0;
    x_sel_c = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_sel_c = weight_q[i];
        x_sel_c = input_q[i];
      end
    end
    prod_c = PROD_W'($signed(w_sel_c)) * PROD_W'($signed(x_sel_c));
    sum_c  = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'(prod_c);
    ovf_c  = sum_c[ACC_W] ^ sum_c[ACC_W-1];
    if (ovf_c) begin
      mac_c = sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      mac_c = sum_c[ACC_W-1:0];
    end
  end

  // Next-state: bus writes first, then the FSM so that status sets win.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
    bias_d      = bias_q;
    mode_d      = mode_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    sat_d       = sat_q;
    weight_d    = weight_q;
    input_d     = input_q;
    start_c     = 1'b0;
    ack_d       = req_c;
    dat_d       = rd_c ? rdata_c : 32'd0;

    if (wr_c) begin
      case (reg_idx_c)
        REG_CTRL: begin
          if (!busy_q) begin
            start_c  = wbs_dat_i[0];
            mode_d   = wbs_dat_i[1];
            irq_en_d = wbs_dat_i[2];
          end
        end
        REG_STATUS: begin
          if (wbs_dat_i[1]) done_d = 1'b0;
          if (wbs_dat_i[2]) sat_d  = 1'b0;
        end
        REG_BIAS: begin
          if (!busy_q) bias_d = wbs_dat_i[ACC_W-1:0];
        end
        default: begin
          for (int unsigned i = 0; i < CH; i++) begin
            if (!busy_q && nib_ok_c && (nib_c == 4'(i))) begin
              if (reg_idx_c[7:4] == GRP_WEIGHT) weight_d[i] = wbs_dat_i[DW-1:0];
              if (reg_idx_c[7:4] == GRP_INPUT)  input_d[i]  = wbs_dat_i[DW-1:0];
            end
          end
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = S_RUN;
          acc_d   = bias_q;
          idx_d   = '0;
          done_d  = 1'b0;
          sat_d   = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = mac_c;
        if (ovf_c) sat_d = 1'b1;
        if (idx_q == IDX_W'(CH - 1)) begin
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_FIN: begin
        result_d = (mode_q && acc_q[ACC_W-1]) ? '0 : acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    irq_d       = done_d & irq_en_d;
    ch_active_d = (state_d == S_RUN) ? (CH'(1) << idx_d) : '0;
  end

  // State and register file, cleared asynchronously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      bias_q      <= '0;
      mode_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      ch_active_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        weight_q[i] <= '0;
        input_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      bias_q      <= bias_d;
      mode_q      <= mode_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
      irq_q       <= irq_d;
      ch_active_q <= ch_active_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      for (int unsigned i = 0; i < CH; i++) begin
        weight_q[i] <= weight_d[i];
        input_q[i]  <= input_d[i];
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign irq_o       = irq_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sat_o       = sat_q;
  assign ch_active_o = ch_active_q;
  assign la_dbg_o    = result_q[7:0];

endmodule

// File: tb/tb_wb_mac_neuron_n.sv
// Directed bench for wb_mac_neuron_n (CH=4, DW=8, ACC_W=20).
module tb_wb_mac_neuron_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        irq, busy, done, sat;
  logic [3:0]  ch_active;
  logic [7:0]  la_dbg;

  int vectors = 0;
  int miscompares = 0;

  wb_mac_neuron_n #(.CH(4), .DW(8), .ACC_W(20)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .irq_o(irq), .busy_o(busy), .done_o(done), .sat_o(sat),
    .ch_active_o(ch_active), .la_dbg_o(la_dbg)
  );

  always #5 clk = ~clk;

  // One Wishbone transfer; returns just after the ack edge.
  task automatic wb_xfer(input logic w, input logic [7:0] idx, input logic [31:0] d,
                         output logic [31:0] q);
    logic ok;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {8'h00, idx, 16'h0000}; wdat = d;
    ok = 1'b0;
    q = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1'b1; q = rdat; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ack_timeout idx=%h: got no ack, expected ack within 4 cycles", idx);
    end
  endtask

  task automatic wb_write(input logic [7:0] idx, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, d, dummy);
  endtask

  task automatic wb_read(input logic [7:0] idx, output logic [31:0] q);
    wb_xfer(1'b0, idx, 32'h0, q);
  endtask

  task automatic load(input logic [3:0][7:0] w, input logic [3:0][7:0] x, input logic [31:0] b);
    for (int i = 0; i < 4; i++) wb_write(8'h10 + 8'(i), 32'($signed(w[i])));
    for (int i = 0; i < 4; i++) wb_write(8'h20 + 8'(i), 32'($signed(x[i])));
    wb_write(8'h02, b);
  endtask

  // Writes CTRL with start and counts cycles with busy high (bounded).
  task automatic start_run(input logic [31:0] ctrl, output int cyc_busy);
    wb_write(8'h00, ctrl);
    cyc_busy = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      cyc_busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] q;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ack, rdat, irq, busy, done, sat, ch_active, la_dbg} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {ack, rdat, irq, busy, done, sat, ch_active, la_dbg});
    end
    @(negedge clk); rst = 1'b0;
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", q); end
    wb_read(8'h02, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL reset_bias: got %h expected 0", q); end
  endtask

  task automatic test_regs();
    logic [31:0] q;
    wb_write(8'h10, 32'hFFFF_FFFD);
    wb_read(8'h10, q);
    vectors++;
    if (q !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL weight_sext: got %h expected fffffffd", q); end
    wb_write(8'h14, 32'h0000_0055);
    wb_read(8'h14, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL weight_oob: got %h expected 0", q); end
    wb_write(8'h00, 32'h0000_0006);
    wb_read(8'h00, q);
    vectors++;
    if (q !== 32'h6) begin miscompares++; $display("FAIL ctrl_rw: got %h expected 6", q); end
    wb_write(8'h00, 32'h0);
  endtask

  task automatic test_basic();
    logic [31:0] q;
    int nb;
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 32'd5);
    wb_write(8'h00, 32'h1);
    nb = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      vectors++;
      if (ch_active !== ((i < 4) ? (4'b0001 << i) : 4'b0000)) begin
        miscompares++;
        $display("FAIL ch_active cyc%0d: got %b expected %b", i, ch_active,
                 (i < 4) ? (4'b0001 << i) : 4'b0000);
      end
      nb++;
      @(posedge clk); #1;
    end
    vectors++;
    if (nb !== 5) begin miscompares++; $display("FAIL busy_len: got %0d expected 5", nb); end
    vectors++;
    if ({done, sat, la_dbg} !== {1'b1, 1'b0, 8'h31}) begin
      miscompares++;
      $display("FAIL basic_flags: got done=%b sat=%b la=%h expected 1 0 31", done, sat, la_dbg);
    end
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'd305) begin miscompares++; $display("FAIL basic_result: got %0d expected 305", q); end
  endtask

  task automatic test_relu();
    logic [31:0] q;
    int nb;
    load({8'd0, 8'd0, 8'd0, 8'hFF}, {8'd0, 8'd0, 8'd0, 8'd100}, 32'd0);
    start_run(32'h1, nb);
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'hFFFF_FF9C) begin miscompares++; $display("FAIL linear_neg: got %h expected ffffff9c", q); end
    start_run(32'h3, nb);
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL relu_neg: got %h expected 0", q); end
  endtask

  task automatic test_saturation();
    logic [31:0] q;
    int nb;
    load({4{8'h80}}, {4{8'h80}}, 32'd500000);
    start_run(32'h1, nb);
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'd524287) begin miscompares++; $display("FAIL sat_pos: got %0d expected 524287", q); end
    wb_read(8'h01, q);
    vectors++;
    if (q !== 32'h6 || sat !== 1'b1) begin
      miscompares++; $display("FAIL sat_status: got %h sat_o=%b expected 6 1", q, sat);
    end
    wb_write(8'h01, 32'h4);
    wb_read(8'h01, q);
    vectors++;
    if (q !== 32'h2 || sat !== 1'b0) begin
      miscompares++; $display("FAIL sat_clear: got %h sat_o=%b expected 2 0", q, sat);
    end
    load({4{8'h80}}, {4{8'h7F}}, 32'($signed(-500000)));
    wb_read(8'h02, q);
    vectors++;
    if (q !== 32'($signed(-500000))) begin miscompares++; $display("FAIL bias_sext: got %h expected fff85ee0", q); end
    start_run(32'h1, nb);
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'hFFF8_0000 || sat !== 1'b1) begin
      miscompares++; $display("FAIL sat_neg: got %h sat_o=%b expected fff80000 1", q, sat);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] q;
    int rises;
    logic prev;
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 32'd5);
    wb_write(8'h00, 32'h1);
    wb_write(8'h10, 32'd7);
    wb_write(8'h00, 32'h1);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_during_writes: got %b expected 1", busy); end
    rises = 0;
    prev = done;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done && !prev) rises++;
      prev = done;
    end
    vectors++;
    if (rises !== 1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_done: got %0d rises busy=%b expected 1 0", rises, busy);
    end
    wb_read(8'h10, q);
    vectors++;
    if (q !== 32'd1) begin miscompares++; $display("FAIL weight_locked: got %0d expected 1", q); end
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'd305) begin miscompares++; $display("FAIL busy_result: got %0d expected 305", q); end
  endtask

  task automatic test_irq();
    logic [31:0] q;
    int nb;
    start_run(32'h5, nb);
    vectors++;
    if ({done, irq} !== 2'b11) begin miscompares++; $display("FAIL irq_set: got %b expected 11", {done, irq}); end
    wb_write(8'h01, 32'h2);
    vectors++;
    if ({done, irq} !== 2'b00) begin miscompares++; $display("FAIL irq_clear: got %b expected 00", {done, irq}); end
    wb_read(8'h3F, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL read_3f: got %h expected 0", q); end
    @(posedge clk); #1;
    vectors++;
    if ({ack, rdat} !== 33'h0) begin
      miscompares++; $display("FAIL ack_one_cycle: got ack=%b dat=%h expected 0 0", ack, rdat);
    end
    wb_read(8'h14, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL read_14: got %h expected 0", q); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] q;
    logic hit;
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 32'd5);
    wb_write(8'h00, 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (ch_active === 4'b0100) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL reach_idx2: got ch_active=%b expected 0100", ch_active); end
    rst = 1'b1;
    #1;
    vectors++;
    if ({ack, rdat, irq, busy, done, sat, ch_active, la_dbg} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %h expected 0",
               {ack, rdat, irq, busy, done, sat, ch_active, la_dbg});
    end
    @(negedge clk); rst = 1'b0;
    wb_read(8'h10, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL abort_weight: got %h expected 0", q); end
    wb_read(8'h21, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL abort_input: got %h expected 0", q); end
    repeat (8) @(posedge clk);
    #1;
    wb_read(8'h03, q);
    vectors++;
    if (q !== 32'h0 || done !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_done: got result=%h done=%b expected 0 0", q, done);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic();
    test_relu();
    test_saturation();
    test_busy_writes();
    test_irq();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_mac_neuron_n.md
# wb_mac_neuron_n

Parametrised Wishbone-slave neuron accelerator for the user project area. It holds CH signed weights, CH signed inputs and a bias. On a start command it runs a sequential saturating multiply-accumulate, then applies an optional ReLU. It extends the fixed 4-weight neuron with configurable channel count and width, saturation detection, ReLU mode, and a done interrupt; status flags are exported for IO pads and the logic analyzer.

## Interface
- CH, 4, number of weight/input channels (1..16)
- DW, 8, signed width of each weight and input
- ACC_W, 20, signed accumulator/bias width; must be ≥ 2*DW+clog2(CH) and ≤ 32
- wb_clk_i  in  1  single clock, all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe, write enable
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word
- wbs_adr_i  in  32  address; register index = wbs_adr_i[23:16]
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data, valid while ack high, 0 otherwise
- irq_o  out  1  done & irq_en, level
- busy_o, done_o, sat_o  out  1 each  status mirrors for IO pads
- ch_active_o  out  CH  one-hot of channel being accumulated during RUN, else 0
- la_dbg_o  out  8  RESULT[7:0]

## Operation
Register map (index = adr[23:16]):
- 0x00 CTRL, RW: bit0 start (write-1 pulse, reads 0); bit1 mode (0 linear, 1 ReLU); bit2 irq_en.
- 0x01 STATUS: bit0 busy (RO); bit1 done (sticky, write 1 to clear); bit2 sat (sticky, write 1 to clear).
- 0x02 BIAS, RW: ACC_W bits, sign-extended on read.
- 0x03 RESULT, RO: ACC_W bits, sign-extended.
- 0x10+i WEIGHT[i] and 0x20+i INPUT[i], RW for i<CH: DW bits, sign-extended on read.
- All other indices, including i≥CH: read 0, writes dropped, still acked.

Bus behaviour:
- A write commits on the edge where cyc&stb&~ack.
- While busy, writes to WEIGHT, INPUT, BIAS and CTRL are dropped but acked. This includes start; the STATUS clear bits still work.

State machine:
- IDLE: start commit → RUN; acc←BIAS, idx←0, done←0, sat←0.
- RUN: each cycle acc←sat(acc + WEIGHT[idx]*INPUT[idx]), idx++.
- RUN exit: after idx = CH-1 is processed → FIN.
- FIN: RESULT←(mode && acc<0) ? 0 : acc; done←1; → IDLE.

Arithmetic:
- Products are full 2*DW signed and sign-extended to ACC_W+1.
- If the sum exceeds the ACC_W signed range, acc is clamped to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and sat is set.
- Accumulation continues from the clamped value.

## Timing
- Reset: every output 0, all registers 0, state IDLE, ack 0. An assertion mid-RUN aborts immediately and RESULT stays 0.
- Ack: high exactly one cycle, on the cycle after the request is sampled. Back-to-back requests are therefore acked every other cycle.
- Start committed at edge E0:
  - busy_o rises after E0.
  - MACs occur at E1..E_CH.
  - FIN at E_CH+1: RESULT and done_o valid and busy_o low after E_CH+1.
  - busy_o is high CH+1 cycles in total.
- ch_active_o[k] is high during the cycle before edge E_(k+1).
- A STATUS done-clear write in the same cycle as FIN: the set wins.

## Test plan
- CH=4, DW=8, ACC_W=20; W={1,2,3,4}, X={10,20,30,40}, BIAS=5, mode 0, start → RESULT=305, busy_o high exactly 5 cycles, done_o=1, sat=0, la_dbg_o=0x31.
- W={-1,0,0,0}, X={100,0,0,0}, BIAS=0, mode 0 → RESULT reads 0xFFFFFF9C; repeat with mode 1 → RESULT=0.
- W all -128, X all -128, BIAS=500000 → RESULT=524287, sat=1 sticky until STATUS write 0x4.
- During busy, write WEIGHT[0]=7 and CTRL start → both acked, WEIGHT[0] unchanged, a single done pulse occurs, RESULT unaffected.
- irq_en=1: done raises irq_o the cycle after FIN; write STATUS=0x2 → irq_o=0; read 0x3F and 0x14 → 0 with a one-cycle ack.
- Assert wb_rst_i during RUN at idx 2 → all outputs 0 immediately, WEIGHT/INPUT read back 0, no done.
